// File: rtl/frame_fwd_pkg.sv
// Shared word format and state encoding for the frame forwarding path.
// A word is {flag, byte}: flag=1 carries a frame byte, flag=0 is a gap or end marker.
package frame_fwd_pkg;

    localparam int WORD_W   = 9;
    localparam int FLAG_BIT = 8;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t END_MARKER = 9'h000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FWD   = 2'd1,
        ST_DROP  = 2'd2,
        ST_TRUNC = 2'd3
    } fwd_state_e;

    function automatic logic is_byte(input word_t w);
        return w[FLAG_BIT];
    endfunction

endpackage

// File: rtl/frame_fwd_skid.sv
// Registered write port with a one-word skid: a word that meets a stall is parked and
// written once stall drops. Input to write strobe is 1 cycle when not stalled.
module frame_fwd_skid
    import frame_fwd_pkg::*;
(
    input  logic  sys_clk,
    input  logic  sys_rstn,
    input  logic  in_vld_i,
    input  word_t in_dat_i,
    input  logic  stall_i,
    output logic  hold_o,
    output logic  out_vld_o,
    output word_t out_dat_o
);

    logic  skid_vld_q, skid_vld_d;
    word_t skid_dat_q, skid_dat_d;
    logic  out_vld_q, out_vld_d;
    word_t out_dat_q, out_dat_d;

    // The upstream never offers a new word while the skid is occupied.
    always_comb begin
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        out_vld_d  = 1'b0;
        out_dat_d  = out_dat_q;
        if (skid_vld_q) begin
            if (!stall_i) begin
                out_vld_d  = 1'b1;
                out_dat_d  = skid_dat_q;
                skid_vld_d = 1'b0;
            end
        end else if (in_vld_i) begin
            if (stall_i) begin
                skid_vld_d = 1'b1;
                skid_dat_d = in_dat_i;
            end else begin
                out_vld_d = 1'b1;
                out_dat_d = in_dat_i;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            skid_vld_q <= 1'b0;
            skid_dat_q <= END_MARKER;
            out_vld_q  <= 1'b0;
            out_dat_q  <= END_MARKER;
        end else begin
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
        end
    end

    assign hold_o    = skid_vld_q;
    assign out_vld_o = out_vld_q;
    assign out_dat_o = out_dat_q;

endmodule

// File: rtl/frame_fwd.sv
// Frame-atomic forwarding from an rx FIFO to a tx FIFO with drop-at-start, truncation and stats.
// rd_en to wr_en is 2 cycles; wr_full stalls reads in FWD and parks an in-flight word in the skid.
module frame_fwd
    import frame_fwd_pkg::*;
#(
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rstn,
    output logic              rd_en,
    input  logic [WORD_W-1:0] rd_data,
    input  logic              rd_empty,
    output logic              wr_en,
    output logic [WORD_W-1:0] wr_data,
    input  logic              wr_full,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  trunc_cnt,
    output logic              busy
);

    localparam int                BCNT_W   = $clog2(MAX_LEN + 1);
    localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(MAX_LEN);

    fwd_state_e        state_q;
    logic [BCNT_W-1:0] byte_cnt_q;
    logic              rd_pend_q;
    logic              run_q;
    logic [CNT_W-1:0]  frame_cnt_q;
    logic [CNT_W-1:0]  drop_cnt_q;
    logic [CNT_W-1:0]  trunc_cnt_q;

    logic              skid_hold;
    logic              wr_req;
    word_t             wr_word;
    logic              at_limit;

    assign at_limit = (byte_cnt_q >= BCNT_MAX);

    // Only FWD has to write every word it reads, so only FWD honours wr_full before reading.
    assign rd_en = run_q && !rd_empty && !skid_hold && (!wr_full || (state_q != ST_FWD));

    always_comb begin
        wr_req  = 1'b0;
        wr_word = END_MARKER;
        if (rd_pend_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_byte(rd_data) && !wr_full) begin
                        wr_req  = 1'b1;
                        wr_word = rd_data;
                    end
                end
                ST_FWD: begin
                    wr_req  = 1'b1;
                    wr_word = (is_byte(rd_data) && at_limit) ? END_MARKER : rd_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= '0;
            rd_pend_q   <= 1'b0;
            run_q       <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            trunc_cnt_q <= '0;
        end else begin
            run_q     <= 1'b1;
            rd_pend_q <= rd_en;
            if (rd_pend_q) begin
                case (state_q)
                    ST_IDLE: begin
                        if (is_byte(rd_data)) begin
                            if (!wr_full) begin
                                byte_cnt_q <= BCNT_W'(1);
                                state_q    <= ST_FWD;
                            end else begin
                                drop_cnt_q <= drop_cnt_q + CNT_W'(1);
                                state_q    <= ST_DROP;
                            end
                        end
                    end
                    ST_FWD: begin
                        if (!is_byte(rd_data)) begin
                            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                            state_q     <= ST_IDLE;
                        end else if (at_limit) begin
                            trunc_cnt_q <= trunc_cnt_q + CNT_W'(1);
                            state_q     <= ST_TRUNC;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + BCNT_W'(1);
                        end
                    end
                    ST_DROP: begin
                        if (!is_byte(rd_data)) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_TRUNC: begin
                        if (!is_byte(rd_data)) begin
                            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                            state_q     <= ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    frame_fwd_skid u_skid (
        .sys_clk   (sys_clk),
        .sys_rstn  (sys_rstn),
        .in_vld_i  (wr_req),
        .in_dat_i  (wr_word),
        .stall_i   (wr_full),
        .hold_o    (skid_hold),
        .out_vld_o (wr_en),
        .out_dat_o (wr_data)
    );

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign trunc_cnt = trunc_cnt_q;
    assign busy      = (state_q == ST_FWD) || (state_q == ST_TRUNC);

endmodule
